// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the hazard/EX/memory sources and the pipeline controller.
// master drives requests and observes controls; slave is the controller side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall_req;
  logic             redirect;
  logic             dmem_busy;
  logic             imem_busy;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             redirect_take;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall_req, redirect, dmem_busy, imem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
    input  redirect_take, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stall_req, redirect, dmem_busy, imem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
    output redirect_take, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit for a 5-stage RISC-V core: stage enables/flushes, deferred
// redirects across memory waits, a stall watchdog and saturating performance counters.
module pipeline_ctrl #(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            rstn,
  pipeline_ctrl_if.slave bus
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] MAX_V = SW'(MAX_STALL);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIR_PEND} state_t;

  state_t           state, state_nx;
  logic             pend, pend_nx;
  logic [SW-1:0]    stall_run, stall_run_nx;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, take;
  logic redir_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A pending flag only exists outside RUN; it outranks everything but dmem_busy.
  assign redir_now = (pend && state != RUN) || bus.redirect;

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    take        = 1'b0;
    state_nx    = state;
    pend_nx     = pend;
    if (!rstn) begin
      state_nx = RUN;
      pend_nx  = 1'b0;
    end else if (bus.dmem_busy) begin
      state_nx = MEM_WAIT;
      pend_nx  = pend | bus.redirect;
    end else if (redir_now) begin
      // Wrong-path work is squashed now even if the fetch port cannot take the target yet.
      if_id_we    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      if (bus.imem_busy) begin
        state_nx = REDIR_PEND;
        pend_nx  = 1'b1;
      end else begin
        pc_we    = 1'b1;
        take     = 1'b1;
        state_nx = RUN;
        pend_nx  = 1'b0;
      end
    end else begin
      state_nx  = RUN;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      if (bus.stall_req) begin
        id_ex_flush = 1'b1;
      end else if (bus.imem_busy) begin
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
      end
    end
  end

  always_comb begin
    stall_run_nx = stall_run;
    if (!bus.stall_req)
      stall_run_nx = '0;
    else if (!bus.dmem_busy && stall_run != MAX_V)
      stall_run_nx = stall_run + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      pend      <= 1'b0;
      stall_run <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      stall_run <= stall_run_nx;
      if (stall_run_nx == MAX_V)
        timeout <= 1'b1;
      if (!pc_we)
        stall_cnt <= sat_inc(stall_cnt);
      if (take)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.pc_we         = pc_we;
  assign bus.if_id_we      = if_id_we;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_we     = ex_mem_we;
  assign bus.mem_wb_we     = mem_wb_we;
  assign bus.redirect_take = take;
  assign bus.stall_timeout = timeout;
  assign bus.stall_cycles  = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver pushes expected outputs from a behavioural
// model, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 16;
  localparam int LIM       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             take;
    logic             timeout;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit m_pend;
  int m_run;
  bit m_to;
  int m_sc;
  int m_fc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, expv);
    end
  endtask

  // One clock cycle of stimulus; expected outputs for this cycle are queued before the edge.
  task automatic step(input bit r, input bit sr, input bit rd, input bit db, input bit ib);
    obs_t e;
    rstn          = r;
    bus.stall_req = sr;
    bus.redirect  = rd;
    bus.dmem_busy = db;
    bus.imem_busy = ib;
    e = '0;
    if (!r) begin
      m_pend = 0; m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      e.timeout = m_to;
      e.sc      = CNT_W'(m_sc);
      e.fc      = CNT_W'(m_fc);
      if (db) begin
        m_pend = m_pend | rd;
      end else if (m_pend || rd) begin
        e.if_id_we = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
        e.ex_mem_we = 1; e.mem_wb_we = 1;
        if (ib) m_pend = 1;
        else begin
          e.pc_we = 1; e.take = 1; m_pend = 0;
        end
      end else if (sr) begin
        e.id_ex_flush = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
      end else if (ib) begin
        e.if_id_we = 1; e.if_id_flush = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
      end else begin
        e.pc_we = 1; e.if_id_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
      end
      if (!e.pc_we && m_sc < LIM) m_sc++;
      if (e.take && m_fc < LIM) m_fc++;
      if (!sr) m_run = 0;
      else if (!db && m_run < MAX_STALL) m_run++;
      if (m_run >= MAX_STALL) m_to = 1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_we",         32'(bus.pc_we),         32'(e.pc_we));
      chk("if_id_we",      32'(bus.if_id_we),      32'(e.if_id_we));
      chk("if_id_flush",   32'(bus.if_id_flush),   32'(e.if_id_flush));
      chk("id_ex_flush",   32'(bus.id_ex_flush),   32'(e.id_ex_flush));
      chk("ex_mem_we",     32'(bus.ex_mem_we),     32'(e.ex_mem_we));
      chk("mem_wb_we",     32'(bus.mem_wb_we),     32'(e.mem_wb_we));
      chk("redirect_take", 32'(bus.redirect_take), 32'(e.take));
      chk("stall_timeout", 32'(bus.stall_timeout), 32'(e.timeout));
      chk("stall_cycles",  32'(bus.stall_cycles),  32'(e.sc));
      chk("flush_count",   32'(bus.flush_count),   32'(e.fc));
    end
  end

  initial begin
    #1ms;
    $display("FAIL time_limit t=%0t actual=running expected=finished", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int p_sr, p_rd, p_db, p_ib;
    rstn          = 1'b0;
    bus.stall_req = 1'b0;
    bus.redirect  = 1'b0;
    bus.dmem_busy = 1'b0;
    bus.imem_busy = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    idle(10);
    // single-cycle stall
    step(1, 1, 0, 0, 0);
    idle(2);
    // redirect wins over stall
    step(1, 1, 1, 0, 0);
    idle(2);
    // redirect deferred behind a 3-cycle memory wait
    step(1, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    idle(3);
    // watchdog
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
    idle(3);
    // reset asserted mid-cycle while stalled
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
    idle(3);
    // redirect blocked by fetch, then retried
    step(1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    // pending redirect discarded by reset
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(3);

    for (int blk = 0; blk < 12; blk++) begin
      p_sr = (blk % 3 == 0) ? 95 : (blk % 3 == 1) ? 40 : 10;
      p_rd = $urandom_range(5, 30);
      p_db = $urandom_range(0, 30);
      p_ib = $urandom_range(0, 30);
      for (int i = 0; i < 200; i++)
        step(($urandom_range(0, 149) != 0),
             ($urandom_range(0, 99) < p_sr),
             ($urandom_range(0, 99) < p_rd),
             ($urandom_range(0, 99) < p_db),
             ($urandom_range(0, 99) < p_ib));
      step(0, 0, 0, 0, 0);
    end

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
